// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encoding, divisor floor and frame-length constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int unsigned DIV_MIN_DEFAULT = 4;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned START_BITS      = 1;
    localparam int unsigned STOP_BITS       = 1;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PARITY_BITS     = 1;
`else
    localparam int unsigned PARITY_BITS     = 0;
`endif
    localparam int unsigned FRAME_BITS      = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } rx_state_e;
`endif

    function automatic logic [31:0] clamp_div(input logic [31:0] div, input logic [31:0] div_min);
        return (div < div_min) ? div_min : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO; pushes while full are dropped, pops while empty are ignored.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned     PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_COUNT);
    assign level   = count_q;
    // Full check ignores a same-cycle pop: a byte arriving at a full FIFO is always dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a 2-flop synchronizer feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit checked ahead of the stop bit).
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_MIN    = DIV_MIN_DEFAULT
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    input  logic [31:0]                   div,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [2:0]                    dbg_state
);

    rx_state_e   state_q;
    logic        rx_meta_q;
    logic        rxs_q;
    logic [1:0]  warm_q;
    logic        armed_q;
    logic [31:0] div_q;
    logic [31:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        frame_err_q;
    logic        overrun_q;
`ifdef UART_RX_PARITY_EN
    logic        par_q;
`endif

    logic [31:0] div_clamped;
    logic        cnt_done;
    logic        stop_sample;
    logic        frame_bad;
    logic        push;
    logic        fifo_full;

    assign div_clamped = clamp_div(div, DIV_MIN);
    assign cnt_done    = (cnt_q == 32'd0);
    assign stop_sample = (state_q == ST_STOP) && cnt_done;
`ifdef UART_RX_PARITY_EN
    assign frame_bad   = !rxs_q || (^{shift_q, par_q});
`else
    assign frame_bad   = !rxs_q;
`endif
    assign push        = stop_sample && !frame_bad;

    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign dbg_state   = state_q;

    // The flops reset high, so warm_q marks when rxs_q holds a real line sample;
    // a line that is low out of reset must be seen high before a start bit counts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            warm_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            warm_q    <= {warm_q[0], 1'b1};
            if (warm_q[1] && rxs_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            div_q       <= 32'd0;
            cnt_q       <= 32'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !rxs_q) begin
                        div_q   <= div_clamped;
                        cnt_q   <= div_clamped >> 1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else if (rxs_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q     <= div_q - 32'd1;
                        bit_idx_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= div_q - 32'd1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        par_q   <= rxs_q;
                        cnt_q   <= div_q - 32'd1;
                        state_q <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Returning to IDLE on the sample cycle lets a start bit follow the stop bit directly.
                    if (!cnt_done) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        frame_err_q <= frame_bad;
                        overrun_q   <= !frame_bad && fifo_full;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (shift_q),
        .pop    (out_ready),
        .rdata  (out_data),
        .valid  (out_valid),
        .full   (fifo_full),
        .level  (level)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: serial-line driver plus a byte-queue reference model for uart_rx_core.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_core;
    import uart_rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          rx        = 1'b1;
    logic [31:0]   div       = 32'd104;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          frame_err;
    logic          overrun;
    logic [LW-1:0] level;
    logic [2:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
    bit par_flip = 1'b0;
`endif

    uart_rx_core #(
        .FIFO_DEPTH (DEPTH),
        .DIV_MIN    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .div       (div),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .level     (level),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Observer: inputs change on the falling edge, so sample 1ns later for the next rising edge.
    always @(negedge clk) begin
        #1;
        if (resetn) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        fe_seen = 0;
        ov_seen = 0;
    endtask

    // Drives one frame starting at the current falling edge; bit period is max(d, 4) cycles.
    task automatic send_frame(input logic [7:0] b, input int d, input bit stop_val);
        int bc;
        bc  = (d < 4) ? 4 : d;
        div = 32'(d);
        rx  = 1'b0;
        cycles(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(bc);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        cycles(bc);
`endif
        rx = stop_val;
        cycles(bc);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx = 1'b0; out_ready = 1'b1; div = 32'd104;
        cycles(4);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_vec++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %02h expected 00", out_data); end
        n_vec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        resetn = 1'b1;
        cycles(30);
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_low_line: got state %0d expected %0d", dbg_state, ST_IDLE); end
        rx = 1'b1;
        cycles(10);
        n_vec++; if (level !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_empty_pop: got level %0d valid %b expected 0 0", level, out_valid); end
    endtask

    task automatic test_basic();
        clear_obs();
        out_ready = 1'b1;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 104, 1'b1);
        cycles(2 * 104);
        n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL basic_data: got %02h expected %02h", got_q[0], exp_q[0]); end
        n_vec++; if (fe_seen !== 0 || ov_seen !== 0) begin n_err++; $display("FAIL basic_pulses: got fe=%0d ov=%0d expected 0 0", fe_seen, ov_seen); end
    endtask

    task automatic test_glitch();
        clear_obs();
        out_ready = 1'b0; div = 32'd104;
        rx = 1'b0;
        cycles(20);
        rx = 1'b1;
        cycles(200);
        n_vec++; if (level !== '0) begin n_err++; $display("FAIL glitch_level: got %0d expected 0", level); end
        n_vec++; if (fe_seen !== 0) begin n_err++; $display("FAIL glitch_fe: got %0d expected 0", fe_seen); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_frame_err();
        clear_obs();
        out_ready = 1'b0;
        send_frame(8'hA5, 104, 1'b0);
        cycles(3 * 104);
        n_vec++; if (fe_seen !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d expected 1", fe_seen); end
        n_vec++; if (level !== '0) begin n_err++; $display("FAIL ferr_level: got %0d expected 0", level); end
        n_vec++; if (ov_seen !== 0) begin n_err++; $display("FAIL ferr_ov: got %0d expected 0", ov_seen); end
    endtask

    task automatic test_back_to_back();
        int fe_exp;
        bit done;
        fe_exp = 0;
        done = 1'b0;
        clear_obs();
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    logic [7:0] b;
                    int d;
                    bit stop_ok;
                    bit good;
                    b = 8'($urandom_range(0, 255));
                    d = $urandom_range(0, 24);
                    stop_ok = ($urandom_range(0, 3) != 0);
                    good = stop_ok;
`ifdef UART_RX_PARITY_EN
                    par_flip = ($urandom_range(0, 3) == 0);
                    good = stop_ok && !par_flip;
`endif
                    if (good) exp_q.push_back(b);
                    else fe_exp++;
                    send_frame(b, d, stop_ok);
                    if (!stop_ok) cycles(2 * ((d < 4) ? 4 : d));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    cycles(1);
                end
            end
        join
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        out_ready = 1'b1;
        cycles(100);
        n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (fe_seen !== fe_exp) begin n_err++; $display("FAIL b2b_fe: got %0d expected %0d", fe_seen, fe_exp); end
        n_vec++; if (ov_seen !== 0) begin n_err++; $display("FAIL b2b_ov: got %0d expected 0", ov_seen); end
    endtask

    task automatic test_overrun();
        int ov_exp;
        ov_exp = 0;
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
            else ov_exp++;
            send_frame(8'(i), 16, 1'b1);
        end
        cycles(48);
        n_vec++; if (level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovr_level: got %0d expected %0d", level, DEPTH); end
        n_vec++; if (ov_seen !== ov_exp) begin n_err++; $display("FAIL ovr_pulses: got %0d expected %0d", ov_seen, ov_exp); end
        n_vec++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_err++; $display("FAIL ovr_head: got valid %b data %02h expected 1 %02h", out_valid, out_data, exp_q[0]); end
        out_ready = 1'b1;
        cycles(16);
        n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovr_drain_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr_drain[%0d]: got %02h expected %02h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (level !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_empty: got level %0d valid %b expected 0 0", level, out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h3C;
        clear_obs();
        out_ready = 1'b1; div = 32'd104;
        rx = 1'b0;
        cycles(104);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            cycles(104);
        end
        rx = b[3];
        cycles(52);
        resetn = 1'b0;
        cycles(3);
        n_vec++; if (level !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_empty: got level %0d valid %b expected 0 0", level, out_valid); end
        n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        rx = 1'b1;
        resetn = 1'b1;
        cycles(3 * 104);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 104, 1'b1);
        cycles(2 * 104);
        n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL midrst_data: got %02h expected %02h", got_q[0], exp_q[0]); end
        n_vec++; if (fe_seen !== 0) begin n_err++; $display("FAIL midrst_fe: got %0d expected 0", fe_seen); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_obs();
        out_ready = 1'b1;
        par_flip = 1'b1;
        send_frame(8'h01, 104, 1'b1);
        cycles(2 * 104);
        n_vec++; if (fe_seen !== 1) begin n_err++; $display("FAIL par_bad_fe: got %0d expected 1", fe_seen); end
        n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL par_bad_push: got %0d bytes expected 0", got_q.size()); end
        par_flip = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 104, 1'b1);
        cycles(2 * 104);
        n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL par_good_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL par_good_data: got %02h expected %02h", got_q[0], exp_q[0]); end
        n_vec++; if (fe_seen !== 1) begin n_err++; $display("FAIL par_good_fe: got %0d expected 1", fe_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
